// File: rtl/shared_reg_initiator.sv
// GP-core requester for the shared register file: turns single core commands into
// timed en/we/addr/wdata drives and retries with backoff when RT collides.
module shared_reg_initiator #(
    parameter int unsigned MAX_RETRY = 4,
    parameter int unsigned BACKOFF   = 1,
    parameter int unsigned STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              srf_en,
    output logic              srf_we,
    output logic [2:0]        srf_addr,
    output logic [31:0]       srf_wdata,
    input  logic [31:0]       srf_rdata,
    input  logic              srf_collision,
    output logic [STAT_W-1:0] retry_total
);

    localparam int unsigned RcW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned BoW = (BACKOFF < 2) ? 1 : $clog2(BACKOFF + 1);

    localparam logic [1:0] OpRead     = 2'b00;
    localparam logic [1:0] OpWrite    = 2'b01;
    localparam logic [1:0] OpFetchAdd = 2'b11;

    typedef enum logic [2:0] {StIdle, StRd, StWr, StBackoff, StResp} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [2:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        old_q, old_d;
    logic [RcW-1:0]     retry_cnt_q, retry_cnt_d;
    logic [BoW-1:0]     backoff_cnt_q, backoff_cnt_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [STAT_W-1:0]  retry_total_q, retry_total_d;
    logic               retry;
    state_e             first_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            op_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            old_q         <= '0;
            retry_cnt_q   <= '0;
            backoff_cnt_q <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            retry_total_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            old_q         <= old_d;
            retry_cnt_q   <= retry_cnt_d;
            backoff_cnt_q <= backoff_cnt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            retry_total_q <= retry_total_d;
        end
    end

    // An RMW always restarts from the read so a stale old value is never reused.
    assign first_phase = (op_q == OpWrite) ? StWr : StRd;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        old_d         = old_q;
        retry_cnt_d   = retry_cnt_q;
        backoff_cnt_d = backoff_cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        retry_total_d = retry_total_q;
        retry         = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    retry_cnt_d = '0;
                    state_d     = (cmd_op == OpWrite) ? StWr : StRd;
                end
            end
            StRd: begin
                if (srf_collision) begin
                    retry = 1'b1;
                end else begin
                    old_d = srf_rdata;
                    if (op_q == OpRead) begin
                        rsp_data_d = srf_rdata;
                        rsp_err_d  = 1'b0;
                        state_d    = StResp;
                    end else begin
                        state_d = StWr;
                    end
                end
            end
            StWr: begin
                if (srf_collision) begin
                    retry = 1'b1;
                end else begin
                    rsp_data_d = (op_q == OpWrite) ? wdata_q : old_q;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end
            end
            StBackoff: begin
                if (backoff_cnt_q == '0) begin
                    state_d = first_phase;
                end else begin
                    backoff_cnt_d = backoff_cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d   = StIdle;
                    rsp_err_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (retry) begin
            if (retry_cnt_q == RcW'(MAX_RETRY)) begin
                rsp_err_d  = 1'b1;
                rsp_data_d = '0;
                state_d    = StResp;
            end else begin
                retry_cnt_d = retry_cnt_q + 1'b1;
                if (retry_total_q != '1) begin
                    retry_total_d = retry_total_q + 1'b1;
                end
                if (BACKOFF == 0) begin
                    state_d = first_phase;
                end else begin
                    backoff_cnt_d = BoW'(BACKOFF - 1);
                    state_d       = StBackoff;
                end
            end
        end
    end

    // File drives decode straight from state so an async reset drops them at once.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        srf_en    = 1'b0;
        srf_we    = 1'b0;
        srf_addr  = '0;
        srf_wdata = '0;
        case (state_q)
            StRd: begin
                srf_en   = 1'b1;
                srf_addr = addr_q;
            end
            StWr: begin
                srf_en    = 1'b1;
                srf_we    = 1'b1;
                srf_addr  = addr_q;
                srf_wdata = (op_q == OpFetchAdd) ? (old_q + wdata_q) : wdata_q;
            end
            default: ;
        endcase
    end

    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign retry_total = retry_total_q;

endmodule

// File: tb/tb_shared_reg_initiator.sv
// Bench for shared_reg_initiator: a register-file model with injected RT collisions,
// checked against a transaction-level reference of each command's outcome.
module tb_shared_reg_initiator;

    localparam int unsigned MaxRetry = 4;
    localparam int unsigned Backoff  = 1;
    localparam int unsigned StatW    = 16;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [2:0]        cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              srf_en;
    logic              srf_we;
    logic [2:0]        srf_addr;
    logic [31:0]       srf_wdata;
    logic [31:0]       srf_rdata;
    logic              srf_collision;
    logic [StatW-1:0]  retry_total;

    shared_reg_initiator #(
        .MAX_RETRY (MaxRetry),
        .BACKOFF   (Backoff),
        .STAT_W    (StatW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .srf_en        (srf_en),
        .srf_we        (srf_we),
        .srf_addr      (srf_addr),
        .srf_wdata     (srf_wdata),
        .srf_rdata     (srf_rdata),
        .srf_collision (srf_collision),
        .retry_total   (retry_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: the shared file plus an RT core that wins every collision.
    logic [31:0] mem [8];
    logic [15:0] coll_bits;
    logic [31:0] rt_val;
    int          ptr;

    assign srf_rdata     = mem[srf_addr];
    assign srf_collision = srf_en && coll_bits[ptr[3:0]];

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            ptr <= 0;
        end else if (srf_en) begin
            ptr <= ptr + 1;
        end
        if (srf_en) begin
            if (srf_collision) begin
                mem[srf_addr] <= rt_val;
            end else if (srf_we) begin
                mem[srf_addr] <= srf_wdata;
            end
        end
    end

    // Reference state
    logic [31:0] ref_mem [8];
    int          ref_total;
    int          checks;
    int          errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Transaction-level outcome: walk attempts, consuming one collision bit per access cycle.
    task automatic model(input logic [1:0] op, input logic [2:0] a, input logic [31:0] wd,
                         output logic [31:0] data, output logic err, output int cycles,
                         output int en_cnt, output int we_cnt);
        int          idx;
        int          retries;
        bit          done;
        bit          collided;
        logic [31:0] old;
        idx = 0; retries = 0; done = 0; cycles = 0; en_cnt = 0; we_cnt = 0;
        data = 0; err = 0; old = 0;
        while (!done) begin
            collided = 0;
            if (op != 2'b01) begin
                en_cnt++; cycles++;
                if (coll_bits[idx]) begin
                    ref_mem[a] = rt_val;
                    collided = 1;
                end else begin
                    old = ref_mem[a];
                    if (op == 2'b00) begin
                        data = old;
                        done = 1;
                    end
                end
                idx++;
            end
            if (!collided && !done) begin
                en_cnt++; we_cnt++; cycles++;
                if (coll_bits[idx]) begin
                    ref_mem[a] = rt_val;
                    collided = 1;
                end else begin
                    ref_mem[a] = (op == 2'b11) ? old + wd : wd;
                    data = (op == 2'b01) ? wd : old;
                    done = 1;
                end
                idx++;
            end
            if (collided) begin
                if (retries == int'(MaxRetry)) begin
                    err = 1;
                    data = 0;
                    done = 1;
                end else begin
                    retries++;
                    cycles += Backoff;
                end
            end
        end
        ref_total = (ref_total + retries > 65535) ? 65535 : ref_total + retries;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, input logic [31:0] wd,
                           input int stall, output logic [31:0] got);
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_cyc;
        int          exp_en;
        int          exp_we;
        int          cyc;
        int          en_cnt;
        int          we_cnt;
        model(op, a, wd, exp_data, exp_err, exp_cyc, exp_en, exp_we);
        @(negedge clk);
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = wd;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cyc = 0; en_cnt = 0; we_cnt = 0;
        while (cyc < 200) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (srf_en) en_cnt++;
            if (srf_we) we_cnt++;
            cyc++;
        end
        check_eq("latency", 32'(cyc), 32'(exp_cyc));
        check_eq("en_cycles", 32'(en_cnt), 32'(exp_en));
        check_eq("we_cycles", 32'(we_cnt), 32'(exp_we));
        check_eq("rsp_data", rsp_data, exp_data);
        check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
        check_eq("retry_total", 32'(retry_total), 32'(ref_total));
        got = rsp_data;
        for (int i = 0; i < stall; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom);
            cmd_wdata = $urandom;
            @(negedge clk);
            check_eq("stall_valid", 32'(rsp_valid), 32'd1);
            check_eq("stall_data", rsp_data, exp_data);
            check_eq("stall_ready", 32'(cmd_ready), 32'd0);
            check_eq("stall_en", 32'(srf_en), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check_eq("rsp_drop", 32'(rsp_valid), 32'd0);
        check_eq("ready_back", 32'(cmd_ready), 32'd1);
        check_eq("err_clear", 32'(rsp_err), 32'd0);
        check_eq("mem", mem[a], ref_mem[a]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_en"}, 32'(srf_en), 32'd0);
        check_eq({tag, "_we"}, 32'(srf_we), 32'd0);
        check_eq({tag, "_addr"}, 32'(srf_addr), 32'd0);
        check_eq({tag, "_wdata"}, srf_wdata, 32'd0);
        check_eq({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rspd"}, rsp_data, 32'd0);
        check_eq({tag, "_rspe"}, 32'(rsp_err), 32'd0);
        check_eq({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
        check_eq({tag, "_tot"}, 32'(retry_total), 32'd0);
    endtask

    logic [31:0] got;
    int          cyc;

    initial begin
        checks = 0; errors = 0; ref_total = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 1'b0; coll_bits = '0; rt_val = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_cmd(2'b01, 3'(i), $urandom, 0, got);

        // Plain write/read round trip
        run_cmd(2'b01, 3'd2, 32'hDEADBEEF, 0, got);
        run_cmd(2'b00, 3'd2, 32'h0, 0, got);
        check_eq("rd_s2", got, 32'hDEADBEEF);
        check_eq("tot_zero", 32'(retry_total), 32'd0);

        // Fetch-add, including wraparound
        run_cmd(2'b01, 3'd3, 32'd10, 0, got);
        run_cmd(2'b11, 3'd3, 32'd5, 0, got);
        check_eq("fa_old", got, 32'd10);
        check_eq("fa_new", mem[3], 32'd15);
        run_cmd(2'b01, 3'd3, 32'hFFFFFFFF, 0, got);
        run_cmd(2'b11, 3'd3, 32'd2, 0, got);
        check_eq("fa_wrap_old", got, 32'hFFFFFFFF);
        check_eq("fa_wrap_new", mem[3], 32'd1);

        // Swap with a collision on the first write phase
        run_cmd(2'b01, 3'd5, 32'd7, 0, got);
        coll_bits = 16'b0010; rt_val = 32'd7;
        run_cmd(2'b10, 3'd5, 32'd9, 0, got);
        check_eq("swap_old", got, 32'd7);
        check_eq("swap_new", mem[5], 32'd9);
        check_eq("swap_tot", 32'(retry_total), 32'd1);

        // Persistent collision exhausts retries
        coll_bits = '1; rt_val = 32'h1234_5678;
        run_cmd(2'b01, 3'd6, 32'hCAFEF00D, 0, got);
        check_eq("exh_tot", 32'(retry_total), 32'd5);
        coll_bits = '0;

        // Long response stall
        run_cmd(2'b00, 3'd2, 32'h0, 6, got);

        // Reset during the write phase of a fetch-add
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_addr = 3'd4; cmd_wdata = 32'd3;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_pre_we", 32'(srf_we), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        ref_total = 0;
        cyc = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) cyc++;
        end
        check_eq("midrst_norsp", 32'(cyc), 32'd0);
        rst_n = 1'b1;
        check_eq("midrst_mem", mem[4], ref_mem[4]);
        run_cmd(2'b00, 3'd4, 32'h0, 0, got);

        // Randomized traffic with random collisions and stalls
        for (int n = 0; n < 80; n++) begin
            for (int b = 0; b < 16; b++) coll_bits[b] = ($urandom_range(0, 99) < 20);
            rt_val = $urandom;
            run_cmd(2'($urandom), 3'($urandom), $urandom, int'($urandom_range(0, 2)), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_reg_initiator.md
Name: shared_reg_initiator

Overview:
- GP-core-side requester for the shared register file (S0-S7). Converts single-command core requests into cycle-accurate en/we/addr/wdata drives toward the file: READ, WRITE, SWAP, FETCH_ADD.
- Monitors the file's collision flag. A GP access that coincides with an RT access to the same register is retried with backoff, because RT has write priority.
- Read and write phases are back-to-back, so any RT write to the same register during an RMW is flagged and the whole RMW restarts. This makes SWAP/FETCH_ADD atomic semaphore primitives for inter-core sync.

Parameters:
- MAX_RETRY, 4, retries allowed after the first attempt before the command fails with error.
- BACKOFF, 1, idle cycles (srf_en=0) between a collided attempt and its retry. 0 means retry on the next cycle.
- STAT_W, 16, width of the saturating total-retry statistics counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  core command valid.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_op  in  2  00 READ, 01 WRITE, 10 SWAP, 11 FETCH_ADD.
- cmd_addr  in  3  shared register index.
- cmd_wdata  in  32  write data, or addend for FETCH_ADD.
- rsp_valid  out  1  response valid, held until accepted.
- rsp_ready  in  1  core accepts response.
- rsp_data  out  32  response data.
- rsp_err  out  1  command failed (retries exhausted).
- srf_en  out  1  shared file enable.
- srf_we  out  1  shared file write enable.
- srf_addr  out  3  shared file address.
- srf_wdata  out  32  shared file write data.
- srf_rdata  in  32  shared file read data (combinational, same cycle).
- srf_collision  in  1  shared file collision flag (same cycle).
- retry_total  out  STAT_W  saturating count of all retries since reset.

Behaviour:
- Reset: state IDLE; cmd_ready=1; rsp_valid=0, rsp_data=0, rsp_err=0; srf_en=0, srf_we=0, srf_addr=0, srf_wdata=0; retry_total=0; internal op/addr/wdata/old_q/retry_cnt/backoff_cnt cleared.
- srf_* outputs decode from state. Reset asserted mid-command aborts immediately: srf_en drops asynchronously and no response is produced.
- States: IDLE, RD, WR, BACKOFF, RESP.
- IDLE:
  - On cmd_valid && cmd_ready, latch op/addr/wdata and set retry_cnt=0.
  - Next state is WR for WRITE, otherwise RD.
  - cmd_* is ignored in every other state.
- RD: srf_en=1, srf_we=0, srf_addr=addr_q. At the clock edge:
  - If srf_collision: go to retry handling.
  - Else capture old_q=srf_rdata. READ goes to RESP with rsp_data=srf_rdata. SWAP/FETCH_ADD go to WR.
- WR: srf_en=1, srf_we=1, srf_addr=addr_q.
  - srf_wdata = wdata_q for WRITE/SWAP; (old_q + wdata_q) mod 2^32 for FETCH_ADD, carry discarded.
  - At the edge, if srf_collision: go to retry handling.
  - Else go to RESP. rsp_data = wdata_q for WRITE; old_q for SWAP/FETCH_ADD.
- Retry handling (collision in RD or WR):
  - If retry_cnt == MAX_RETRY: go to RESP with rsp_err=1, rsp_data=0.
  - Else retry_cnt++ and retry_total++ (saturating at all-ones).
  - Then go to BACKOFF for BACKOFF cycles, or directly if BACKOFF=0, and restart at the first phase (RD, or WR for WRITE).
  - An RMW always restarts from RD; a partial RMW result is never used.
- BACKOFF: srf_en=0; count down, then enter the first phase.
- RESP: rsp_valid=1 with rsp_data/rsp_err stable. On rsp_ready, go to IDLE, rsp_valid=0 and rsp_err=0 next cycle.
- Latency with no collision:
  - READ/WRITE: accept → 1 access cycle → rsp_valid on the next cycle.
  - SWAP/FETCH_ADD: 2 access cycles.
- Each collided attempt adds 1 + BACKOFF cycles.
- Worst case before error: (MAX_RETRY+1) attempts.
- A READ collides only if RT writes the same register in that cycle; it is retried so the post-write value is returned.
- No command pipelining: at most one command in flight.

Test Plan:
- Idle file, no collisions: WRITE S2=0xDEADBEEF, then READ S2 → rsp_data=0xDEADBEEF, rsp_err=0, srf_en high exactly 1 cycle per command, retry_total=0.
- S3=10, FETCH_ADD S3 +5 → rsp_data=10, S3=15, srf_en high 2 consecutive cycles (we=0 then we=1). Repeat with S3=0xFFFFFFFF +2 → rsp_data=0xFFFFFFFF, S3=1.
- SWAP S5 (=7) with 9, srf_collision forced high in the WR cycle of the first attempt only → 1 idle BACKOFF cycle, RD restarts, rsp_data=7, S5=9, retry_total=1.
- srf_collision held high for a WRITE, MAX_RETRY=4 → exactly 5 srf_we pulses, then rsp_valid with rsp_err=1, rsp_data=0, retry_total=4.
- rsp_ready held low for 6 cycles after READ completes → rsp_valid/rsp_data stable all 6 cycles, cmd_ready=0, a new cmd_valid is ignored. After rsp_ready, cmd_ready=1 the following cycle.
- rst_n asserted during the WR phase of FETCH_ADD → srf_en=0 immediately, rsp_valid never asserts, all outputs at reset values. After release, a READ completes normally.
